// File: rtl/uart_echo_buf_if.sv
// Receiver/transmitter handshake and status bundle for uart_echo_buf.
// slave is the echo buffer side, master is the side driving it.
interface uart_echo_buf_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              eor_i;
   logic [DATA_W-1:0] d_i;
   logic              pcheck_i;
   logic              eot_i;
   logic              en_i;
   logic              clr_i;
   logic              sttx_o;
   logic [DATA_W-1:0] d_o;
   logic [CW-1:0]     count_o;
   logic              empty_o;
   logic              full_o;
   logic              ovf_o;
   logic [7:0]        perr_o;
   logic              busy_o;

   modport slave (
      input  eor_i, d_i, pcheck_i, eot_i, en_i, clr_i,
      output sttx_o, d_o, count_o, empty_o, full_o, ovf_o, perr_o, busy_o
   );

   modport master (
      output eor_i, d_i, pcheck_i, eot_i, en_i, clr_i,
      input  sttx_o, d_o, count_o, empty_o, full_o, ovf_o, perr_o, busy_o
   );
endinterface

// File: rtl/uart_echo_buf.sv
// UART echo buffer: received words are queued in a FIFO and replayed to the
// transmitter one at a time (pop -> load d_o -> start pulse -> wait for eot).
// Parity-error words are counted and optionally dropped; overflow is sticky.
module uart_echo_buf #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter bit DROP_ERR = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   uart_echo_buf_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] d_q;
   logic              ovf_q;
   logic [7:0]        perr_q;
   logic              empty, full;
   logic              push_req, push, pop, err_evt, ovf_evt;
   logic              sttx, busy;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign err_evt  = bus.eor_i & bus.pcheck_i;
   assign push_req = bus.eor_i & ~(DROP_ERR & bus.pcheck_i);
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign push     = push_req & (~full | pop);
   assign ovf_evt  = push_req & full & ~pop;

   // FIFO storage: data only, no reset needed.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= bus.d_i;
   end

   // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Output word register, loaded with the FIFO head on the IDLE->LOAD pop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) d_q <= '0;
      else if (pop) d_q <= mem[rd_ptr];
   end

   // Sticky overflow and saturating parity-error count; a new event beats clr.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q  <= 1'b0;
         perr_q <= 8'd0;
      end else if (bus.clr_i) begin
         ovf_q  <= ovf_evt;
         perr_q <= err_evt ? 8'd1 : 8'd0;
      end else begin
         ovf_q  <= ovf_q | ovf_evt;
         if (err_evt) perr_q <= sat_inc8(perr_q);
      end
   end

   // Echo FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Echo FSM next state and decoded outputs.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      sttx      = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.en_i && !empty) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:  state_nxt = START;
         START: begin
            sttx      = 1'b1;
            state_nxt = WAIT;
         end
         WAIT:  if (bus.eot_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.sttx_o  = sttx;
   assign bus.busy_o  = busy;
   assign bus.d_o     = d_q;
   assign bus.count_o = count;
   assign bus.empty_o = empty;
   assign bus.full_o  = full;
   assign bus.ovf_o   = ovf_q;
   assign bus.perr_o  = perr_q;
endmodule

// File: tb/tb_uart_echo_buf.sv
// Bench for uart_echo_buf: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_uart_echo_buf;
   localparam int DATA_W   = 8;
   localparam int DEPTH    = 16;
   localparam int DROP_ERR = 1;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   always #5 clk_i = ~clk_i;

   uart_echo_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   uart_echo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_ERR(1'b1)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, required 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // reference model: words waiting, plus the word currently being echoed
   logic [7:0] q[$];
   bit         m_busy;
   int         m_age;    // edges since the word was taken from the queue
   logic [7:0] m_word;
   bit         m_ovf;
   int         m_perr;

   // stimulus and transmitter responder
   logic       s_eor, s_pc, s_en, s_clr, s_eot_extra;
   logic [7:0] s_d;
   bit         tx_hold;
   int         tx_cnt;
   logic [7:0] got[$];

   function automatic void model_reset();
      q.delete();
      m_busy = 0;
      m_age  = 0;
      m_word = 8'h00;
      m_ovf  = 0;
      m_perr = 0;
   endfunction

   function automatic void model_edge(input bit eot);
      bit pop, err_evt, ovf_evt;
      pop = !m_busy && s_en && (q.size() > 0);
      if (m_busy) begin
         if (m_age >= 2) begin
            if (eot) m_busy = 0;
         end else begin
            m_age++;
         end
      end
      if (pop) begin
         m_word = q.pop_front();
         m_busy = 1;
         m_age  = 0;
      end
      err_evt = s_eor && s_pc;
      ovf_evt = 0;
      if (s_eor && !(DROP_ERR != 0 && s_pc)) begin
         if (q.size() < DEPTH) q.push_back(s_d);
         else ovf_evt = 1;
      end
      if (s_clr) begin
         m_ovf  = ovf_evt;
         m_perr = err_evt ? 1 : 0;
      end else begin
         m_ovf = m_ovf || ovf_evt;
         if (err_evt && m_perr < 255) m_perr++;
      end
   endfunction

   task automatic tick();
      logic eot_v;
      eot_v = 1'b0;
      if (!tx_hold && tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) eot_v = 1'b1;
      end
      eot_v = eot_v | s_eot_extra;
      bus.eor_i    = s_eor;
      bus.d_i      = s_d;
      bus.pcheck_i = s_pc;
      bus.en_i     = s_en;
      bus.clr_i    = s_clr;
      bus.eot_i    = eot_v;
      @(posedge clk_i);
      model_edge(eot_v);
      #1;
      chk("count", 32'(bus.count_o), 32'(q.size()));
      chk("empty", 32'(bus.empty_o), 32'(q.size() == 0));
      chk("full",  32'(bus.full_o),  32'(q.size() == DEPTH));
      chk("ovf",   32'(bus.ovf_o),   32'(m_ovf));
      chk("perr",  32'(bus.perr_o),  32'(m_perr));
      chk("busy",  32'(bus.busy_o),  32'(m_busy));
      chk("sttx",  32'(bus.sttx_o),  32'(m_busy && m_age == 1));
      chk("d_o",   32'(bus.d_o),     32'(m_word));
      if (bus.sttx_o === 1'b1) begin
         tx_cnt = int'($urandom_range(2, 5));
         got.push_back(bus.d_o);
      end
      s_eor = 0; s_pc = 0; s_clr = 0; s_eot_extra = 0;
   endtask

   task automatic push(input logic [7:0] d, input bit pc);
      s_eor = 1;
      s_d   = d;
      s_pc  = pc;
      tick();
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && (q.size() > 0 || m_busy); i++) tick();
      chk("drain_empty", 32'(bus.empty_o), 32'd1);
      chk("drain_busy",  32'(bus.busy_o),  32'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #1;
      chk("rst_count", 32'(bus.count_o), 32'd0);
      chk("rst_empty", 32'(bus.empty_o), 32'd1);
      chk("rst_full",  32'(bus.full_o),  32'd0);
      chk("rst_ovf",   32'(bus.ovf_o),   32'd0);
      chk("rst_perr",  32'(bus.perr_o),  32'd0);
      chk("rst_sttx",  32'(bus.sttx_o),  32'd0);
      chk("rst_d_o",   32'(bus.d_o),     32'd0);
      chk("rst_busy",  32'(bus.busy_o),  32'd0);
      model_reset();
      tx_cnt = 0; tx_hold = 0;
      s_eor = 0; s_pc = 0; s_clr = 0; s_eot_extra = 0; s_d = 8'h00;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int en_pct, eor_pct;
      bus.eor_i = 0; bus.d_i = '0; bus.pcheck_i = 0;
      bus.eot_i = 0; bus.en_i = 0; bus.clr_i = 0;
      s_en = 0;
      do_reset();

      // single word latency
      s_en = 1;
      got.delete();
      push(8'h41, 1'b0);
      chk("sw_count_k", 32'(bus.count_o), 32'd1);
      tick();
      chk("sw_d_o_k1",  32'(bus.d_o),    32'h41);
      chk("sw_busy_k1", 32'(bus.busy_o), 32'd1);
      chk("sw_sttx_k1", 32'(bus.sttx_o), 32'd0);
      tick();
      chk("sw_sttx_k2", 32'(bus.sttx_o), 32'd1);
      tick();
      chk("sw_sttx_k3", 32'(bus.sttx_o), 32'd0);
      chk("sw_busy_k3", 32'(bus.busy_o), 32'd1);
      drain();

      // burst pushed while the first word waits for eot
      do_reset();
      s_en = 1; tx_hold = 1;
      got.delete();
      push(8'h01, 1'b0);
      tick(); tick(); tick();
      for (int i = 2; i <= 5; i++) push(8'(i), 1'b0);
      tx_hold = 0;
      drain();
      chk("burst_len", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("burst_order", 32'(got[i]), 32'(i + 1));

      // overflow with echo disabled
      do_reset();
      s_en = 0;
      for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 1'b0);
      chk("ovf_full",  32'(bus.full_o),  32'd1);
      chk("ovf_count", 32'(bus.count_o), 32'd16);
      chk("ovf_flag",  32'(bus.ovf_o),   32'd1);
      s_clr = 1;
      push(8'hEE, 1'b0);
      chk("ovf_clr_vs_evt", 32'(bus.ovf_o), 32'd1);
      s_clr = 1;
      tick();
      chk("ovf_cleared", 32'(bus.ovf_o), 32'd0);
      got.delete();
      s_en = 1;
      drain();
      chk("ovf_echo_len", 32'(got.size()), 32'd16);
      for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_echo_order", 32'(got[i]), 32'(8'h10 + i));

      // simultaneous push and pop at full
      do_reset();
      s_en = 0;
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 1'b0);
      chk("pp_full_pre", 32'(bus.full_o), 32'd1);
      got.delete();
      s_en = 1;
      push(8'h90, 1'b0);
      chk("pp_count", 32'(bus.count_o), 32'd16);
      chk("pp_ovf",   32'(bus.ovf_o),   32'd0);
      drain();
      chk("pp_len", 32'(got.size()), 32'd17);
      for (int i = 0; i < 17 && i < got.size(); i++) chk("pp_order", 32'(got[i]), 32'(8'h80 + i));

      // parity errors: drop, count, saturate, clear
      do_reset();
      s_en = 0;
      push(8'h55, 1'b1);
      chk("par_count", 32'(bus.count_o), 32'd0);
      chk("par_perr1", 32'(bus.perr_o),  32'd1);
      for (int i = 1; i < 300; i++) push(8'(i), 1'b1);
      chk("par_sat", 32'(bus.perr_o), 32'd255);
      s_clr = 1;
      tick();
      chk("par_clr", 32'(bus.perr_o), 32'd0);
      s_clr = 1;
      push(8'h66, 1'b1);
      chk("par_clr_vs_err", 32'(bus.perr_o), 32'd1);

      // reset while waiting with three words buffered
      do_reset();
      s_en = 1; tx_hold = 1;
      push(8'hA0, 1'b0);
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      push(8'hA3, 1'b0);
      chk("rw_count", 32'(bus.count_o), 32'd3);
      chk("rw_busy",  32'(bus.busy_o),  32'd1);
      chk("rw_sttx",  32'(bus.sttx_o),  32'd0);
      do_reset();
      s_en = 1;
      s_eot_extra = 1;
      got.delete();
      for (int i = 0; i < 6; i++) tick();
      chk("rw_no_echo", 32'(got.size()), 32'd0);
      chk("rw_idle",    32'(bus.busy_o), 32'd0);

      // randomized traffic
      do_reset();
      for (int blk = 0; blk < 10; blk++) begin
         case ($urandom_range(0, 3))
            0:       en_pct = 0;
            1:       en_pct = 50;
            2:       en_pct = 90;
            default: en_pct = 100;
         endcase
         eor_pct = int'($urandom_range(10, 80));
         if (blk == 6) do_reset();
         for (int c = 0; c < 150; c++) begin
            s_en = ($urandom_range(0, 99) < en_pct);
            if ($urandom_range(0, 99) < eor_pct) begin
               s_eor = 1;
               s_d   = 8'($urandom);
               s_pc  = ($urandom_range(0, 9) == 0);
            end
            s_clr = ($urandom_range(0, 49) == 0);
            if (!m_busy && $urandom_range(0, 19) == 0) s_eot_extra = 1;
            tick();
         end
      end
      s_en = 1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
